// File: rtl/alsu_seg_display.sv
// Four-digit multiplexed seven-segment driver for the ALSU result and error blink.
// Takes one snapshot per frame, converts it with double-dabble and swaps it in at the frame boundary.
module alsu_seg_display #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  value_in,
   input  logic [15:0] leds_in,
   input  logic        hex_mode,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_R     = 7'b0101111;

   logic [PW-1:0] presc;
   logic [1:0]    slot;
   logic          wrap;
   logic          snap;
   logic          err_acc;

   logic [5:0]    snap_val;
   logic          snap_hex;
   logic          snap_err;

   logic [1:0]    state;
   logic [2:0]    cnt;
   logic [13:0]   dd;
   logic [13:0]   dd_adj;

   logic [6:0]    pend [4];
   logic          pend_hex;
   logic [6:0]    disp [4];
   logic          disp_hex;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   assign wrap = (presc == PW'(REFRESH_DIV - 1));
   assign snap = wrap && (slot == 2'd2);

   // dd = {tens, ones, remaining binary}; adjust both BCD nibbles before each shift
   always_comb begin
      dd_adj = dd;
      if (dd[13:10] >= 4'd5) dd_adj[13:10] = dd[13:10] + 4'd3;
      if (dd[9:6]   >= 4'd5) dd_adj[9:6]   = dd[9:6]   + 4'd3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         slot     <= '0;
         err_acc  <= 1'b0;
         snap_val <= '0;
         snap_hex <= 1'b0;
         snap_err <= 1'b0;
         state    <= IDLE;
         cnt      <= '0;
         dd       <= '0;
         pend_hex <= 1'b0;
         disp_hex <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) begin
            pend[i] <= G_BLANK;
            disp[i] <= G_BLANK;
         end
         an       <= '1;
         seg      <= G_BLANK;
         dp       <= 1'b1;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) slot <= slot + 2'd1;

         err_acc <= snap ? 1'b0 : (err_acc | (|leds_in));

         if (snap) begin
            snap_val <= value_in;
            snap_hex <= hex_mode;
            snap_err <= err_acc | (|leds_in);
         end

         case (state)
            IDLE: begin
               if (snap) begin
                  dd    <= {8'd0, value_in};
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               dd  <= {dd_adj[12:0], 1'b0};
               cnt <= cnt + 3'd1;
               if (cnt == 3'd5) state <= DONE;
            end
            DONE: begin
               pend_hex <= snap_hex;
               pend[3]  <= snap_err ? G_E : G_BLANK;
               pend[2]  <= snap_err ? G_R : G_BLANK;
               if (snap_err) begin
                  pend[1] <= G_R;
                  pend[0] <= G_BLANK;
               end else if (snap_hex) begin
                  pend[1] <= glyph({2'b00, snap_val[5:4]});
                  pend[0] <= glyph(snap_val[3:0]);
               end else begin
                  pend[1] <= (dd[13:10] == 4'd0) ? G_BLANK : glyph(dd[13:10]);
                  pend[0] <= glyph(dd[9:6]);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (wrap && (slot == 2'd3)) begin
            for (int unsigned i = 0; i < 4; i++) disp[i] <= pend[i];
            disp_hex <= pend_hex;
         end

         an  <= ~(4'b0001 << slot);
         seg <= disp[slot];
         dp  <= ~((slot == 2'd3) && disp_hex);
      end
   end

endmodule

// File: tb/tb_alsu_seg_display.sv
// Directed bench for alsu_seg_display with REFRESH_DIV=8 (32-cycle frames).
module tb_alsu_seg_display;

   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_0     = 7'b1000000;
   localparam logic [6:0] G_2     = 7'b0100100;
   localparam logic [6:0] G_3     = 7'b0110000;
   localparam logic [6:0] G_4     = 7'b0011001;
   localparam logic [6:0] G_5     = 7'b0010010;
   localparam logic [6:0] G_6     = 7'b0000010;
   localparam logic [6:0] G_B     = 7'b0000011;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_R     = 7'b0101111;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  value_in;
   logic [15:0] leds_in;
   logic        hex_mode;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [6:0] cap_seg [4];
   logic       cap_dp  [4];
   logic [3:0] cap_an  [32];

   alsu_seg_display #(.REFRESH_DIV(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .value_in (value_in),
      .leds_in  (leds_in),
      .hex_mode (hex_mode),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Records one 32-cycle frame starting at the current negedge.
   task automatic capture_frame();
      for (int d = 0; d < 4; d++) begin
         cap_seg[d] = 7'h00;
         cap_dp[d]  = 1'bx;
      end
      for (int i = 0; i < 32; i++) begin
         cap_an[i] = an;
         for (int d = 0; d < 4; d++)
            if (an[d] == 1'b0) begin
               cap_seg[d] = seg;
               cap_dp[d]  = dp;
            end
         @(negedge clk);
      end
   endtask

   task automatic wait_an(input logic [3:0] target);
      int unsigned k = 0;
      while (an !== target && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (an !== target) check_val("wait_an_timeout", {12'd0, an}, {12'd0, target});
   endtask

   // Lands on the first negedge of the next frame (an just turned 1110).
   task automatic sync_frame();
      wait_an(4'b0111);
      wait_an(4'b1110);
   endtask

   task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0, input logic edp3);
      check_val({tag, "_d3"}, {9'd0, cap_seg[3]}, {9'd0, e3});
      check_val({tag, "_d2"}, {9'd0, cap_seg[2]}, {9'd0, e2});
      check_val({tag, "_d1"}, {9'd0, cap_seg[1]}, {9'd0, e1});
      check_val({tag, "_d0"}, {9'd0, cap_seg[0]}, {9'd0, e0});
      check_val({tag, "_dp3"}, {15'd0, cap_dp[3]}, {15'd0, edp3});
      check_val({tag, "_dp0"}, {15'd0, cap_dp[0]}, 16'd1);
   endtask

   task automatic show_value(input string tag, input logic [5:0] v, input logic hx,
                             input logic [6:0] e1, input logic [6:0] e0);
      value_in = v;
      hex_mode = hx;
      sync_frame();
      repeat (32) @(negedge clk);
      capture_frame();
      check_frame(tag, G_BLANK, G_BLANK, e1, e0, ~hx);
   endtask

   initial begin
      rst      = 1'b1;
      value_in = 6'd0;
      leds_in  = 16'h0000;
      hex_mode = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_an",  {12'd0, an},  16'h000F);
      check_val("rst_seg", {9'd0, seg},  {9'd0, G_BLANK});
      check_val("rst_dp",  {15'd0, dp},  16'd1);

      rst = 1'b0;
      @(negedge clk);
      capture_frame();
      check_val("f1_an_s0", {12'd0, cap_an[0]},  16'hE);
      check_val("f1_an_s1", {12'd0, cap_an[8]},  16'hD);
      check_val("f1_an_s2", {12'd0, cap_an[16]}, 16'hB);
      check_val("f1_an_s3", {12'd0, cap_an[24]}, 16'h7);
      check_frame("f1_blank", G_BLANK, G_BLANK, G_BLANK, G_BLANK, 1'b1);
      capture_frame();
      check_frame("f2_zero", G_BLANK, G_BLANK, G_BLANK, G_0, 1'b1);

      show_value("dec43", 6'd43, 1'b0, G_4, G_3);
      show_value("hex43", 6'd43, 1'b1, G_2, G_B);
      show_value("dec5",  6'd5,  1'b0, G_BLANK, G_5);
      show_value("hex5",  6'd5,  1'b1, G_0, G_5);
      show_value("dec63", 6'd63, 1'b0, G_6, G_3);

      // One-cycle error blink in slot 1 of the frame whose snapshot feeds the next frame
      sync_frame();
      repeat (10) @(negedge clk);
      leds_in = 16'hFFFF;
      @(negedge clk);
      leds_in = 16'h0000;
      repeat (21) @(negedge clk);
      capture_frame();
      check_frame("err", G_E, G_R, G_R, G_BLANK, 1'b1);
      capture_frame();
      check_frame("after_err", G_BLANK, G_BLANK, G_6, G_3, 1'b1);

      // Reset while the converter is shifting (early in slot 3)
      wait_an(4'b0111);
      check_val("pre_rst_state", {14'd0, dut.state}, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("mid_rst_an",    {12'd0, an},  16'h000F);
      check_val("mid_rst_seg",   {9'd0, seg},  {9'd0, G_BLANK});
      check_val("mid_rst_state", {14'd0, dut.state}, 16'd0);
      rst = 1'b0;
      @(negedge clk);
      capture_frame();
      check_frame("post_rst_blank", G_BLANK, G_BLANK, G_BLANK, G_BLANK, 1'b1);
      capture_frame();
      check_frame("post_rst_val", G_BLANK, G_BLANK, G_6, G_3, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
